pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Pipeline sequencing controller for the 4-stage core (fetch, decode, exec/dmem, writeback).
- Turns exec-stage branch/jump outcomes into a PC redirect plus flush of younger stages.
- Inserts a one-cycle bubble on load-use hazards and freezes the pipe while data memory is outstanding.
- Sole source of stall/flush controls for the stage registers.

Parameters:
XLEN, 32, datapath and PC width
REG_AW, 5, register index width
FLUSH_CYCLES, 2, cycles id_flush/ex_flush stay asserted after a redirect (1..15)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_rs1  in  REG_AW  decode source register 1
id_rs2  in  REG_AW  decode source register 2
id_use_rs1  in  1  decode instruction reads rs1
id_use_rs2  in  1  decode instruction reads rs2
ex_valid  in  1  exec stage holds a valid instruction
ex_rd  in  REG_AW  exec destination register
ex_is_load  in  1  exec instruction is a load
ex_redirect  in  1  exec resolved taken branch, JAL or JALR
ex_target  in  XLEN  exec-computed next PC
dmem_req  in  1  data memory access in flight from exec
dmem_ack  in  1  data memory access complete
pc_load  out  1  fetch loads pc_next this cycle
pc_next  out  XLEN  redirect PC, bit0 forced to 0
if_stall  out  1  hold fetch PC and IF/ID register
id_stall  out  1  hold ID/EX register
ex_stall  out  1  hold EX/WB register, suppress writeback
id_flush  out  1  invalidate IF/ID register
ex_flush  out  1  invalidate ID/EX register (bubble)
misalign_err  out  1  one-cycle pulse: redirect target bit1 set
ctrl_state  out  2  current FSM state (debug)

Behaviour:
- Single clock domain, clk rising edge. Asynchronous active-low reset rst_n.
- While rst_n low:
  - FSM = RUN, flush counter = 0.
  - pc_load = 0, pc_next = 0.
  - all stalls = 0, misalign_err = 0.
  - id_flush = ex_flush = 1, so stage registers come out invalid.
- States: RUN(0), REDIRECT(1), LOAD_BUBBLE(2), MEM_WAIT(3).
- Per-cycle priority: MEM_WAIT condition > redirect > load-use.
- mem condition = ex_valid & dmem_req & ~dmem_ack:
  - Asserts if_stall = id_stall = ex_stall = 1 combinationally the same cycle, no flush.
  - Next state is MEM_WAIT.
  - MEM_WAIT holds all stalls until a cycle with dmem_ack = 1. In that cycle stalls drop to 0 and the next state is RUN.
  - ex_redirect is ignored while the mem condition or MEM_WAIT holds.
- redirect = ex_valid & ex_redirect, in RUN or LOAD_BUBBLE:
  - Same cycle (0 latency): pc_load = 1, pc_next = {ex_target[XLEN-1:1],0}, id_flush = ex_flush = 1.
  - misalign_err = ex_target[1] in that cycle; the redirect still proceeds.
  - Counter loads FLUSH_CYCLES-1; state goes to REDIRECT if the counter is nonzero, else RUN.
- REDIRECT: id_flush = ex_flush = 1, counter decrements, state goes to RUN when counter = 0. A new redirect in REDIRECT reloads PC and restarts the counter.
- load-use = id_valid & ex_valid & ex_is_load & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)):
  - In RUN with no redirect: if_stall = id_stall = 1 and ex_flush = 1 for exactly one cycle; state goes to LOAD_BUBBLE.
  - LOAD_BUBBLE: no stall or flush outputs, state returns to RUN. The hazard cannot re-fire because ex_valid is 0.
- Redirect and load-use in the same cycle: redirect only, no stall.
- x0 never creates a hazard.
- Idle RUN: all controls 0.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined: adds 32-bit outputs perf_stall_cnt, perf_flush_cnt, perf_redirect_cnt.
  - perf_stall_cnt counts cycles with if_stall = 1.
  - perf_flush_cnt counts cycles with id_flush = 1, excluding reset.
  - perf_redirect_cnt counts cycles with pc_load = 1.
  - All three are cleared by rst_n and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package defs gets the ctrl_state_e enum (RUN, REDIRECT, LOAD_BUBBLE, MEM_WAIT) and the FLUSH_CYCLES_DEF constant.
- One sub-module, hazard_detect: purely combinational load-use compare, with the id/ex fields as inputs and load_use as output.
- FSM, counter and output muxing stay in pipeline_ctrl.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with random inputs, then release -> id_flush = ex_flush = 1 during reset, all other outputs 0, ctrl_state = 0 after release.
- Redirect with FLUSH_CYCLES = 2: ex_valid = 1, ex_redirect = 1, ex_target = 0x0000_1003 for one cycle -> same cycle pc_load = 1, pc_next = 0x0000_1002, misalign_err = 1. id_flush = ex_flush = 1 for 2 cycles, then all 0.
- Load-use: ex_is_load = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 -> one cycle of if_stall = id_stall = ex_flush = 1, then RUN. Repeat with ex_rd = 0 -> no stall.
- Mem wait: dmem_req = 1 with dmem_ack low 4 cycles, high on the 5th -> all three stalls high for 4 cycles, low in the ack cycle. A redirect asserted during the wait produces no pc_load.
- Simultaneous: redirect and load-use in the same cycle -> pc_load = 1, flushes asserted, if_stall = 0.
- PIPE_CTRL_PERF_EN: run the redirect test plus the mem-wait test (4-cycle wait) -> perf_redirect_cnt = 1, perf_flush_cnt = 2, perf_stall_cnt = 4.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encoding and the default flush length.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    REDIRECT    = 2'd1,
    LOAD_BUBBLE = 2'd2,
    MEM_WAIT    = 2'd3
  } ctrl_state_e;

  localparam int FLUSH_CYCLES_DEF = 2;
  // Wide enough for FLUSH_CYCLES up to 15.
  localparam int FLUSH_CNT_W      = 4;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: decode reads a register that the load
// currently in exec has not yet returned. x0 never hazards.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                    (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: redirect/flush, load-use bubble and
// data-memory freeze. Define PIPE_CTRL_PERF_EN to add performance counters.
//
// Control contract: stalls hold a stage register, flushes invalidate it;
// all controls are combinational and valid for the current clk cycle.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  output logic              pc_load,
  output logic [XLEN-1:0]   pc_next,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              misalign_err,
  output logic [1:0]        ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_redirect_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e            state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic mem_cond;
  logic redirect;

  logic pc_load_c, if_stall_c, id_stall_c, ex_stall_c;
  logic id_flush_c, ex_flush_c, misalign_c;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  assign mem_cond = ex_valid && dmem_req && !dmem_ack;
  assign redirect = ex_valid && ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: memory freeze, then redirect, then load-use bubble.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_load_c  = 1'b0;
    if_stall_c = 1'b0;
    id_stall_c = 1'b0;
    ex_stall_c = 1'b0;
    id_flush_c = 1'b0;
    ex_flush_c = 1'b0;
    misalign_c = 1'b0;
    if (state_q == MEM_WAIT) begin
      if (dmem_ack) begin
        state_d = RUN;
      end else begin
        if_stall_c = 1'b1;
        id_stall_c = 1'b1;
        ex_stall_c = 1'b1;
      end
    end else if (mem_cond) begin
      if_stall_c = 1'b1;
      id_stall_c = 1'b1;
      ex_stall_c = 1'b1;
      cnt_d      = '0;
      state_d    = MEM_WAIT;
    end else if (redirect) begin
      pc_load_c  = 1'b1;
      id_flush_c = 1'b1;
      ex_flush_c = 1'b1;
      misalign_c = ex_target[1];
      cnt_d      = FLUSH_INIT;
      state_d    = (FLUSH_INIT != '0) ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      id_flush_c = 1'b1;
      ex_flush_c = 1'b1;
      cnt_d      = cnt_q - 1'b1;
      if (cnt_q <= 1) state_d = RUN;
    end else if (state_q == LOAD_BUBBLE) begin
      state_d = RUN;
    end else if (load_use) begin
      if_stall_c = 1'b1;
      id_stall_c = 1'b1;
      ex_flush_c = 1'b1;
      state_d    = LOAD_BUBBLE;
    end
  end

  // Reset forces both flushes so stage registers come out invalid.
  assign pc_load      = rst_n && pc_load_c;
  assign pc_next      = pc_load ? (ex_target & ~XLEN'(1)) : '0;
  assign if_stall     = rst_n && if_stall_c;
  assign id_stall     = rst_n && id_stall_c;
  assign ex_stall     = rst_n && ex_stall_c;
  assign id_flush     = !rst_n || id_flush_c;
  assign ex_flush     = !rst_n || ex_flush_c;
  assign misalign_err = rst_n && misalign_c;
  assign ctrl_state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt    <= '0;
      perf_flush_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      perf_stall_cnt    <= perf_stall_cnt + 32'(if_stall_c);
      perf_flush_cnt    <= perf_flush_cnt + 32'(id_flush_c);
      perf_redirect_cnt <= perf_redirect_cnt + 32'(pc_load_c);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model.
module tb_pipeline_ctrl;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int FLUSH_CYCLES = 2;
  localparam int W            = XLEN + 9;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              id_valid, id_use_rs1, id_use_rs2;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              ex_valid, ex_is_load, ex_redirect;
  logic [XLEN-1:0]   ex_target;
  logic              dmem_req, dmem_ack;

  logic              pc_load, if_stall, id_stall, ex_stall;
  logic              id_flush, ex_flush, misalign_err;
  logic [XLEN-1:0]   pc_next;
  logic [1:0]        ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_flush_cnt, perf_redirect_cnt;
`endif

  pipeline_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .ex_stall     (ex_stall),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .misalign_err (misalign_err),
    .ctrl_state   (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  logic [W-1:0] obs;
  assign obs = {pc_load, pc_next, if_stall, id_stall, ex_stall,
                id_flush, ex_flush, misalign_err, ctrl_state};

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_vec(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    tests_run++;
    assert (o === e) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk(input string tag, input logic [XLEN-1:0] o, input logic [XLEN-1:0] e);
    tests_run++;
    assert (o === e) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks "cycles of flush still owed", "waiting on memory" and
  // "bubble just inserted" instead of an explicit state machine.
  int m_flush_left, n_flush_left;
  bit m_mem_wait, n_mem_wait, m_bubble, n_bubble;

  task automatic model_eval(output logic [W-1:0] e);
    logic e_pc_load, e_if, e_id, e_ex, e_idf, e_exf, e_mis;
    logic [XLEN-1:0] e_pc;
    logic [1:0] e_st;
    bit mem_cond, redir, haz;
    e_pc_load = 0; e_if = 0; e_id = 0; e_ex = 0; e_idf = 0; e_exf = 0; e_mis = 0;
    e_pc = '0;
    n_flush_left = m_flush_left; n_mem_wait = m_mem_wait; n_bubble = m_bubble;
    mem_cond = ex_valid && dmem_req && !dmem_ack;
    redir    = ex_valid && ex_redirect;
    haz      = id_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_mem_wait)            e_st = 2'd3;
    else if (m_flush_left > 0) e_st = 2'd1;
    else if (m_bubble)         e_st = 2'd2;
    else                       e_st = 2'd0;
    if (!rst_n) begin
      e_idf = 1; e_exf = 1; e_st = 2'd0;
      n_flush_left = 0; n_mem_wait = 0; n_bubble = 0;
    end else if (m_mem_wait) begin
      if (dmem_ack) n_mem_wait = 0;
      else begin e_if = 1; e_id = 1; e_ex = 1; end
    end else if (mem_cond) begin
      e_if = 1; e_id = 1; e_ex = 1;
      n_mem_wait = 1; n_flush_left = 0; n_bubble = 0;
    end else if (redir) begin
      e_pc_load = 1; e_pc = ex_target & 32'hFFFF_FFFE;
      e_idf = 1; e_exf = 1; e_mis = ex_target[1];
      n_flush_left = FLUSH_CYCLES - 1; n_bubble = 0;
    end else if (m_flush_left > 0) begin
      e_idf = 1; e_exf = 1;
      n_flush_left = m_flush_left - 1;
    end else if (m_bubble) begin
      n_bubble = 0;
    end else if (haz) begin
      e_if = 1; e_id = 1; e_exf = 1;
      n_bubble = 1;
    end
    e = {e_pc_load, e_pc, e_if, e_id, e_ex, e_idf, e_exf, e_mis, e_st};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = '0; ex_is_load = 0; ex_redirect = 0; ex_target = '0;
    dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic drive_random();
    id_valid    = 1'($urandom_range(0, 1));
    id_rs1      = REG_AW'($urandom_range(0, 3));
    id_rs2      = REG_AW'($urandom_range(0, 3));
    id_use_rs1  = 1'($urandom_range(0, 1));
    id_use_rs2  = 1'($urandom_range(0, 1));
    ex_valid    = 1'($urandom_range(0, 1));
    ex_rd       = REG_AW'($urandom_range(0, 3));
    ex_is_load  = 1'($urandom_range(0, 1));
    ex_redirect = ($urandom_range(0, 5) == 0);
    ex_target   = $urandom;
    dmem_req    = ($urandom_range(0, 7) == 0);
    dmem_ack    = 1'($urandom_range(0, 1));
  endtask

  // Sample on the falling edge, then advance the model on the rising edge.
  task automatic at_neg(input string tag);
    logic [W-1:0] e;
    @(negedge clk);
    model_eval(e);
    exp_q.push_back(e);
    check_vec(tag, obs, exp_q.pop_front());
  endtask

  task automatic commit();
    @(posedge clk);
    m_flush_left = n_flush_left; m_mem_wait = n_mem_wait; m_bubble = n_bubble;
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_flush_left = 0; m_mem_wait = 0; m_bubble = 0;
    drive_idle();

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drive_random();
      at_neg("reset_model");
      chk("reset_id_flush", XLEN'(id_flush), 32'd1);
      chk("reset_ex_flush", XLEN'(ex_flush), 32'd1);
      chk("reset_pc_load", XLEN'(pc_load), 32'd0);
      commit();
    end
    rst_n = 1; drive_idle();
    at_neg("post_reset");
    chk("post_reset_state", XLEN'(ctrl_state), 32'd0);
    chk("post_reset_flush", XLEN'(id_flush), 32'd0);
    commit();

    // Redirect to a misaligned target
    ex_valid = 1; ex_redirect = 1; ex_target = 32'h0000_1003;
    at_neg("redir_c0");
    chk("redir_pc_load", XLEN'(pc_load), 32'd1);
    chk("redir_pc_next", pc_next, 32'h0000_1002);
    chk("redir_misalign", XLEN'(misalign_err), 32'd1);
    chk("redir_flush0", XLEN'({id_flush, ex_flush}), 32'd3);
    commit();
    drive_idle();
    at_neg("redir_c1");
    chk("redir_flush1", XLEN'({id_flush, ex_flush}), 32'd3);
    chk("redir_misalign_pulse", XLEN'(misalign_err), 32'd0);
    commit();
    at_neg("redir_c2");
    chk("redir_flush_done", XLEN'({id_flush, ex_flush}), 32'd0);
    commit();

    // Memory wait: 4 cycles without ack, redirect ignored, ack on 5th
    ex_valid = 1; dmem_req = 1; dmem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      ex_redirect = (i == 2);
      at_neg("mem_wait");
      chk("mem_stalls", XLEN'({if_stall, id_stall, ex_stall}), 32'd7);
      chk("mem_no_pc_load", XLEN'(pc_load), 32'd0);
      commit();
    end
    ex_redirect = 0; dmem_ack = 1;
    at_neg("mem_ack");
    chk("mem_ack_stalls", XLEN'({if_stall, id_stall, ex_stall}), 32'd0);
    commit();
    drive_idle();
    at_neg("mem_idle");
    commit();

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    chk("perf_redirect", perf_redirect_cnt, 32'd1);
    chk("perf_flush", perf_flush_cnt, 32'd2);
    chk("perf_stall", perf_stall_cnt, 32'd4);
    commit();
`endif

    // Load-use on rs2, then bubble cycle, then idle
    id_valid = 1; id_rs2 = 5'd5; id_use_rs2 = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5;
    at_neg("lu_c0");
    chk("lu_stall", XLEN'({if_stall, id_stall, ex_stall, id_flush, ex_flush}), 32'b11001);
    commit();
    ex_valid = 0;
    at_neg("lu_bubble");
    chk("lu_bubble_state", XLEN'(ctrl_state), 32'd2);
    chk("lu_bubble_quiet", XLEN'({if_stall, id_stall, ex_flush}), 32'd0);
    commit();
    drive_idle();
    at_neg("lu_idle");
    commit();

    // x0 destination never hazards
    id_valid = 1; id_rs2 = 5'd0; id_use_rs2 = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd0;
    at_neg("lu_x0");
    chk("lu_x0_no_stall", XLEN'({if_stall, id_stall, ex_flush}), 32'd0);
    commit();
    drive_idle();

    // Redirect and load-use together: redirect wins
    id_valid = 1; id_rs1 = 5'd7; id_use_rs1 = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; ex_redirect = 1; ex_target = 32'h0000_2000;
    at_neg("simul");
    chk("simul_pc_load", XLEN'(pc_load), 32'd1);
    chk("simul_flush", XLEN'({id_flush, ex_flush}), 32'd3);
    chk("simul_no_stall", XLEN'(if_stall), 32'd0);
    commit();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      at_neg("simul_tail");
      commit();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_random();
      at_neg("random");
      commit();
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
